// File: rtl/mdu_pkg.sv
// Shared MDU types: multiplier FSM states and Funct3 encodings.
package mdu_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} mulstate_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

endpackage

// File: rtl/mul_iter_step.sv
// One radix-2^K iteration: |A| times a K-bit multiplier digit, added to the
// upper half of the partial product. The result keeps its carry-out, so it is
// XLEN+K bits wide.
module mul_iter_step #(
  parameter int XLEN = 64,
  parameter int K    = 2
) (
  input  logic [XLEN-1:0]   a_i,
  input  logic [K-1:0]      digit_i,
  input  logic [XLEN-1:0]   acc_i,
  output logic [XLEN+K-1:0] sum_o
);

  // The worst case is (2^XLEN-1)*(2^K-1) + 2^XLEN-1 < 2^(XLEN+K), so this width cannot overflow.
  assign sum_o = ({{K{1'b0}}, a_i} * {{XLEN{1'b0}}, digit_i}) + {{K{1'b0}}, acc_i};

endmodule

// File: rtl/mul_iter.sv
// Iterative unsigned-magnitude multiplier with a final sign fix.
// It returns the full 2*XLEN product for MUL/MULH/MULHSU/MULHU.
// Optional feature: define MUL_EARLY_OUT_EN to leave BUSY as soon as the
// remaining multiplier bits are zero. FIX then realigns P with a shifter.
module mul_iter
  import mdu_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int BITSPERCYCLE = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallM,
  input  logic              FlushE,
  input  logic              MulStartE,
  input  logic [XLEN-1:0]   ForwardedSrcAE,
  input  logic [XLEN-1:0]   ForwardedSrcBE,
  input  logic [2:0]        Funct3E,
  output logic              MulBusyE,
  output logic              MulDoneM,
  output logic [2*XLEN-1:0] ProdM
);

  localparam int K  = BITSPERCYCLE;
  localparam int N  = XLEN / K;
  localparam int CW = $clog2(N + 1);

  mulstate_t         state_q;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   a_q;
  logic              neg_q;
  logic [2*XLEN-1:0] p_q;
  logic [2*XLEN-1:0] prod_q;
  logic              busy_q;
  logic              done_q;

  logic              a_sgn, b_sgn;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic [XLEN+K-1:0] step_sum;
  logic [2*XLEN-1:0] p_d;
  logic [CW-1:0]     cnt_d;
  logic              early;
  logic [2*XLEN-1:0] p_fix;
  logic [2*XLEN-1:0] prod_d;
`ifdef MUL_EARLY_OUT_EN
  logic [31:0]       rem_sh;
  logic [31:0]       fix_sh;
`endif

  assign MulBusyE = busy_q;
  assign MulDoneM = done_q;
  assign ProdM    = prod_q;

  mul_iter_step #(.XLEN(XLEN), .K(K)) u_step (
    .a_i     (a_q),
    .digit_i (p_q[K-1:0]),
    .acc_i   (p_q[2*XLEN-1:XLEN]),
    .sum_o   (step_sum)
  );

  // Operand sign decode, iteration update, and sign fix / realignment.
  always_comb begin
    a_sgn  = ((Funct3E == F3_MULH) || (Funct3E == F3_MULHSU)) && ForwardedSrcAE[XLEN-1];
    b_sgn  = (Funct3E == F3_MULH) && ForwardedSrcBE[XLEN-1];
    a_abs  = a_sgn ? -ForwardedSrcAE : ForwardedSrcAE;
    b_abs  = b_sgn ? -ForwardedSrcBE : ForwardedSrcBE;
    // Shift the consumed digit out. The carry-out lands in the top bits.
    p_d    = {step_sum, p_q[XLEN-1:K]};
    cnt_d  = cnt_q - CW'(1);
`ifdef MUL_EARLY_OUT_EN
    // The low cnt_d*K bits of P are the multiplier bits that have not been consumed yet.
    rem_sh = 32'(cnt_d) * K;
    early  = ~|(p_d[XLEN-1:0] & ~({XLEN{1'b1}} << rem_sh));
    fix_sh = 32'(cnt_q) * K;
    p_fix  = p_q >> fix_sh;
`else
    early  = 1'b0;
    p_fix  = p_q;
`endif
    prod_d = neg_q ? -p_fix : p_fix;
  end

  // FSM with registered busy/done and the datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      neg_q   <= 1'b0;
      p_q     <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (MulStartE && !FlushE) begin
            a_q     <= a_abs;
            neg_q   <= a_sgn ^ b_sgn;
            p_q     <= {{XLEN{1'b0}}, b_abs};
            cnt_q   <= CW'(N);
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (FlushE) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            p_q   <= p_d;
            cnt_q <= cnt_d;
            if ((cnt_q == CW'(1)) || early) state_q <= FIX;
          end
        end
        FIX: begin
          busy_q <= 1'b0;
          if (FlushE) begin
            state_q <= IDLE;
          end else begin
            prod_q  <= prod_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          // The result belongs to Memory here, so FlushE has no effect.
          if (!StallM) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_iter.sv
// Scoreboard bench for mul_iter with XLEN=32 and K=2.
// Honours MUL_EARLY_OUT_EN when expecting latencies.
module tb_mul_iter;
  localparam int XLEN = 32;
  localparam int K    = 2;
`ifdef MUL_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, StallM, FlushE, MulStartE;
  logic [31:0] A, B;
  logic [2:0]  F3;
  logic        MulBusyE, MulDoneM;
  logic [63:0] ProdM;

  mul_iter #(.XLEN(XLEN), .BITSPERCYCLE(K)) dut (
    .clk(clk), .reset(reset), .StallM(StallM), .FlushE(FlushE),
    .MulStartE(MulStartE), .ForwardedSrcAE(A), .ForwardedSrcBE(B),
    .Funct3E(F3), .MulBusyE(MulBusyE), .MulDoneM(MulDoneM), .ProdM(ProdM)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [63:0] prod; int t; int lat; int id; } exp_t;
  exp_t sbq[$];
  int   n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Expected cycles from the start cycle to the first MulDoneM.
  function automatic int lat_of(input logic [2:0] f, input logic [31:0] b);
    logic [31:0] m;
    int bl, steps;
    m  = (f == 3'b001 && b[31]) ? -b : b;
    bl = 0;
    for (int i = 0; i < 32; i++) if (m[i]) bl = i + 1;
    steps = (bl + K - 1) / K;
    if (steps < 1) steps = 1;
    return EARLY ? steps + 2 : XLEN / K + 2;
  endfunction

  // Monitor: on each rising MulDoneM, pop the next expected result and compare.
  exp_t e;
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (MulDoneM && !done_prev) begin
      if (sbq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_done got=%h exp=none", ProdM);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("prod#%0d", e.id), ProdM, e.prod);
        chk($sformatf("latency#%0d", e.id), 64'(cyc - e.t), 64'(e.lat));
      end
    end
    done_prev <= MulDoneM;
  end

  // Call at a negedge. Starts are sampled at the following posedge.
  task automatic start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input bit push, input int id);
    F3 = f; A = a; B = b; MulStartE = 1'b1;
    if (push) sbq.push_back('{exp, cyc, lat_of(f, b), id});
    @(negedge clk);
    MulStartE = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 100 && (MulBusyE || MulDoneM || sbq.size() != 0); k++) @(negedge clk);
    if (k >= 100) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout got=busy exp=idle");
      sbq.delete();
    end
  endtask

  logic [2:0]  vf [10] = '{3'b001, 3'b001, 3'b010, 3'b000, 3'b011,
                           3'b001, 3'b001, 3'b000, 3'b011, 3'b001};
  logic [31:0] va [10] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h7, 32'h12345678,
                           32'hFFFFFFFE, 32'h5, 32'hFFFFFFFF, 32'h0, 32'h80000000};
  logic [31:0] vb [10] = '{32'h80000000, 32'h1, 32'hFFFFFFFF, 32'h6, 32'h3,
                           32'h3, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h0, 32'h7FFFFFFF};
  logic [63:0] vp [10] = '{64'h40000000_00000000, 64'hFFFFFFFF_FFFFFFFF,
                           64'hFFFFFFFE_00000002, 64'h00000000_0000002A,
                           64'h00000000_369D0368, 64'hFFFFFFFF_FFFFFFFA,
                           64'hFFFFFFFF_FFFFFFF1, 64'hFFFFFFFE_00000001,
                           64'h00000000_00000000, 64'hC0000000_80000000};

  initial begin
    int t, lat, bad;
    logic [63:0] p0;
    reset = 1'b1; StallM = 1'b0; FlushE = 1'b0; MulStartE = 1'b0;
    A = '0; B = '0; F3 = '0;
    repeat (3) @(negedge clk);
    chk("reset_prod", ProdM, 64'h0);
    chk("reset_busy", 64'(MulBusyE), 64'h0);
    chk("reset_done", 64'(MulDoneM), 64'h0);
    reset = 1'b0;
    @(negedge clk);

    // 1: MULHU all-ones, with the busy window checked
    t = cyc; lat = lat_of(3'b011, 32'hFFFFFFFF);
    start(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b1, 100);
    bad = 0;
    for (int c = t + 1; c <= t + lat; c++) begin
      if (MulBusyE !== (c <= t + lat - 1)) bad++;
      if (c != t + lat) @(negedge clk);
    end
    chk("busy_window_errs", 64'(bad), 64'h0);
    wait_idle();

    // 2/3: directed vector table
    for (int i = 0; i < 10; i++) begin
      wait_idle();
      start(vf[i], va[i], vb[i], vp[i], 1'b1, i);
    end
    wait_idle();

    // 4: flush mid-flight, then restart right away
    p0 = ProdM;
    t = cyc;
    start(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 1'b0, 0);
    repeat (4) @(negedge clk);
    chk("busy_before_flush", 64'(MulBusyE), 64'h1);
    FlushE = 1'b1;
    @(negedge clk);
    FlushE = 1'b0;
    chk("flush_busy", 64'(MulBusyE), 64'h0);
    chk("flush_prod", ProdM, p0);
    chk("flush_cycle", 64'(cyc - t), 64'd6);
    start(3'b011, 32'h3, 32'h5, 64'hF, 1'b1, 200);
    wait_idle();

    // 5: StallM holds DONE
    t = cyc; lat = lat_of(3'b011, 32'h00010001);
    start(3'b011, 32'h0000FFFF, 32'h00010001, 64'h00000000_FFFFFFFF, 1'b1, 300);
    repeat (lat - 1) @(negedge clk);
    StallM = 1'b1;
    p0 = ProdM;
    chk("stall_done0", 64'(MulDoneM), 64'h1);
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (MulDoneM !== 1'b1 || ProdM !== p0) bad++;
    end
    chk("stall_hold_errs", 64'(bad), 64'h0);
    @(negedge clk);
    StallM = 1'b0;
    chk("stall_release_done", 64'(MulDoneM), 64'h1);
    @(negedge clk);
    chk("after_stall_done", 64'(MulDoneM), 64'h0);
    wait_idle();

    // 6: asynchronous reset mid-operation
    start(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 1'b0, 0);
    repeat (6) @(negedge clk);
    chk("busy_before_reset", 64'(MulBusyE), 64'h1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_busy", 64'(MulBusyE), 64'h0);
    chk("async_reset_done", 64'(MulDoneM), 64'h0);
    chk("async_reset_prod", ProdM, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start(3'b010, 32'h80000000, 32'h80000000, 64'hC0000000_00000000, 1'b1, 400);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
